sigma_key_lifo: RTL and testbench

SIGMA_KEY_LIFO -- requirements
Module: sigma_key_lifo

---
 rtl/sigma_key_lifo.sv | 109 ++++++++++
 tb/tb_sigma_key_lifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_key_lifo.sv
// Round-key LIFO for Anubis-style decryption: keys are written in schedule order
// and popped last-first, each popped key XORed onto one incoming state word.
module sigma_key_lifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_wr,
    input  logic [WIDTH-1:0] key_in,
    input  logic             data_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    input  logic             out_ready,
    output logic [4:0]       key_count,
    output logic             err
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [4:0]       count_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             err_reg;
    logic [WIDTH-1:0] key_mem [DEPTH];

    logic             xfer;
    logic             wr_en;
    logic             wr_bad;
    logic [4:0]       pop_ptr;

    assign pop_ptr = count_reg - 5'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: any pop leaves LOAD; popping the last key returns to LOAD
    always_comb begin
        state_next = state_reg;
        if (xfer) begin
            state_next = (count_reg == 5'd1) ? LOAD : RUN;
        end
    end

    // Output / control decode
    always_comb begin
        data_ready = (count_reg != 5'd0) && (!out_valid_reg || out_ready);
        xfer       = data_valid && data_ready;
        // A pop wins over a simultaneous write; the write is then flagged
        wr_en      = key_wr && (state_reg == LOAD) && !xfer && (count_reg < DEPTH_C);
        wr_bad     = key_wr && !wr_en;
    end

    // Key storage is never read while empty, so it carries no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_mem[count_reg[AW-1:0]] <= key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 5'd0;
        end else if (xfer) begin
            count_reg <= count_reg - 5'd1;
        end else if (wr_en) begin
            count_reg <= count_reg + 5'd1;
        end
    end

    // Output register: reload on pop, otherwise drain on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (xfer) begin
            out_reg       <= data_in ^ key_mem[pop_ptr[AW-1:0]];
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (wr_bad) begin
            err_reg <= 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign key_count = count_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_sigma_key_lifo.sv
// Directed bench for sigma_key_lifo: hand-computed vectors checked with immediate assertions.
module tb_sigma_key_lifo;

    localparam int WIDTH = 128;
    localparam int DEPTH = 13;

    logic             clk;
    logic             rst;
    logic             key_wr;
    logic [WIDTH-1:0] key_in;
    logic             data_valid;
    logic [WIDTH-1:0] data_in;
    logic             data_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             out_ready;
    logic [4:0]       key_count;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    sigma_key_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_wr     (key_wr),
        .key_in     (key_in),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .out_valid  (out_valid),
        .out        (out),
        .out_ready  (out_ready),
        .key_count  (key_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        key_wr = 1'b0; data_valid = 1'b0; key_in = '0; data_in = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_key(input logic [WIDTH-1:0] k);
        key_wr = 1'b1; key_in = k;
        tick();
        key_wr = 1'b0;
    endtask

    localparam logic [WIDTH-1:0] ALL_F = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_A = {(WIDTH/2){2'b10}};
    localparam logic [WIDTH-1:0] ALL_5 = {(WIDTH/2){2'b01}};

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 128'(key_count), 128'd0);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_out", out, 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        #1 chk("rst_ready", 128'(data_ready), 128'd0);

        // Empty LIFO ignores data
        data_valid = 1'b1; data_in = 128'h1234;
        #1 chk("empty_ready", 128'(data_ready), 128'd0);
        tick();
        chk("empty_valid", 128'(out_valid), 128'd0);
        chk("empty_err", 128'(err), 128'd0);
        idle();

        // Basic LIFO order
        write_key(128'h1); write_key(128'h2); write_key(128'h4);
        chk("load3_count", 128'(key_count), 128'd3);
        data_valid = 1'b1; data_in = '0;
        #1 chk("load3_ready", 128'(data_ready), 128'd1);
        tick();
        chk("pop0_out", out, 128'h4);
        chk("pop0_valid", 128'(out_valid), 128'd1);
        chk("pop0_count", 128'(key_count), 128'd2);
        tick();
        chk("pop1_out", out, 128'h2);
        chk("pop1_count", 128'(key_count), 128'd1);
        tick();
        chk("pop2_out", out, 128'h1);
        chk("pop2_valid", 128'(out_valid), 128'd1);
        chk("pop2_count", 128'(key_count), 128'd0);
        #1 chk("drained_ready", 128'(data_ready), 128'd0);
        tick();
        chk("drained_valid", 128'(out_valid), 128'd0);
        idle();

        // Back in LOAD: a write is accepted without error
        write_key(ALL_F);
        chk("reload_count", 128'(key_count), 128'd1);
        chk("reload_err", 128'(err), 128'd0);
        data_valid = 1'b1; data_in = ALL_A;
        tick();
        chk("xor_out", out, ALL_5);
        chk("xor_valid", 128'(out_valid), 128'd1);
        idle();
        tick();
        chk("xor_drain", 128'(out_valid), 128'd0);

        // Backpressure
        write_key(128'h10); write_key(128'h20);
        out_ready = 1'b0; data_valid = 1'b1; data_in = 128'h1;
        tick();
        chk("bp_out0", out, 128'h21);
        chk("bp_count0", 128'(key_count), 128'd1);
        data_in = 128'h3;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 128'(data_ready), 128'd0);
            tick();
            chk("bp_hold_out", out, 128'h21);
            chk("bp_hold_valid", 128'(out_valid), 128'd1);
            chk("bp_hold_count", 128'(key_count), 128'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 128'(data_ready), 128'd1);
        tick();
        chk("bp_out1", out, 128'h13);
        chk("bp_valid1", 128'(out_valid), 128'd1);
        chk("bp_count1", 128'(key_count), 128'd0);
        idle();
        tick();
        chk("bp_drain", 128'(out_valid), 128'd0);

        // Write during RUN is ignored and flagged
        write_key(128'h100); write_key(128'h200); write_key(128'h300);
        data_valid = 1'b1; data_in = '0;
        tick();
        chk("run_out0", out, 128'h300);
        idle();
        key_wr = 1'b1; key_in = 128'hBAD;
        tick();
        key_wr = 1'b0;
        chk("run_wr_err", 128'(err), 128'd1);
        chk("run_wr_count", 128'(key_count), 128'd2);
        data_valid = 1'b1; data_in = '0;
        tick();
        chk("run_out1", out, 128'h200);
        tick();
        chk("run_out2", out, 128'h100);
        chk("run_count_end", 128'(key_count), 128'd0);
        chk("run_err_sticky", 128'(err), 128'd1);
        idle();
        tick();

        // Overflow: 14 writes into 13 slots
        do_reset();
        chk("ovf_rst_err", 128'(err), 128'd0);
        for (int i = 0; i < 13; i++) write_key(128'h1000 + 128'(i));
        chk("ovf_full_count", 128'(key_count), 128'd13);
        chk("ovf_full_err", 128'(err), 128'd0);
        write_key(128'h100D);
        chk("ovf_count", 128'(key_count), 128'd13);
        chk("ovf_err", 128'(err), 128'd1);
        data_valid = 1'b1; data_in = '0;
        for (int i = 12; i >= 0; i--) begin
            tick();
            chk("ovf_drain_out", out, 128'h1000 + 128'(i));
        end
        chk("ovf_drain_count", 128'(key_count), 128'd0);
        idle();
        tick();

        // Reset in the middle of RUN
        do_reset();
        for (int i = 0; i < 6; i++) write_key(128'h50 + 128'(i));
        data_valid = 1'b1; data_in = '0;
        tick();
        chk("mid_count", 128'(key_count), 128'd5);
        chk("mid_out", out, 128'h55);
        key_wr = 1'b1;
        tick();
        key_wr = 1'b0;
        chk("mid_err_pre", 128'(err), 128'd1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 128'(key_count), 128'd0);
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_err", 128'(err), 128'd0);
        chk("mid_rst_out", out, 128'd0);
        data_valid = 1'b1; data_in = 128'hF;
        #1 chk("mid_ready", 128'(data_ready), 128'd0);
        tick();
        chk("mid_after_valid", 128'(out_valid), 128'd0);
        idle();

        // Write coinciding with the first pop in LOAD
        write_key(128'h7);
        key_wr = 1'b1; key_in = 128'h9; data_valid = 1'b1; data_in = '0;
        tick();
        idle();
        chk("coll_out", out, 128'h7);
        chk("coll_count", 128'(key_count), 128'd0);
        chk("coll_err", 128'(err), 128'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
